// File: rtl/lr_pkg.sv
// Shared definitions for the feature line buffer and the inner-product stages.
package lr_pkg;

  localparam int unsigned FEAT_DW  = 32;
  localparam int unsigned FEAT_WIN = 41;

  typedef logic [FEAT_DW-1:0] feature_t;
  typedef feature_t feature_array_t [0:FEAT_WIN-1];

endpackage

// File: rtl/feature_window_ctrl.sv
// Column, fill and stride tracking for the window line buffer; decodes when
// an accept completes a stride-aligned window and where that window sits.
module feature_window_ctrl
  import lr_pkg::*;
#(
  parameter int unsigned WIN     = FEAT_WIN,
  parameter int unsigned ROW_LEN = 256,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned CW      = $clog2(ROW_LEN + 1),
  parameter int unsigned PW      = $clog2(ROW_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept,
  input  logic          sof,
  output logic          emit,
  output logic [PW-1:0] pos,
  output logic          last
);

  logic [CW-1:0] col;
  logic [CW-1:0] fill;
  logic [CW-1:0] stride_cnt;
  logic [CW-1:0] col_next;
  logic [CW-1:0] fill_next;
  logic [CW-1:0] stride_cur;
  logic          row_start;
  logic          complete;
  logic          first;
  logic [31:0]   p_ext;

  // Decode the effect of a would-be accept this cycle.
  always_comb begin
    col_next  = sof ? '0 : col;
    row_start = (col_next == '0);
    if (row_start)                fill_next = CW'(1);
    else if (fill == CW'(WIN))    fill_next = fill;
    else                          fill_next = fill + CW'(1);
    complete   = (fill_next == CW'(WIN));
    // The first full window of a row forces the stride phase back to zero.
    first      = complete && (row_start || (fill != CW'(WIN)));
    stride_cur = first ? '0 : stride_cnt;
    emit       = complete && (stride_cur == '0);
    p_ext      = 32'(col_next) - 32'(WIN - 1);
    pos        = p_ext[PW-1:0];
    last       = (p_ext + 32'(STRIDE)) > 32'(ROW_LEN - WIN);
  end

  // Advance the counters on every accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      fill       <= '0;
      stride_cnt <= '0;
    end else if (accept) begin
      col  <= (col_next == CW'(ROW_LEN - 1)) ? '0 : col_next + CW'(1);
      fill <= fill_next;
      if (complete)
        stride_cnt <= (stride_cur == '0) ? CW'(STRIDE - 1) : stride_cur - CW'(1);
    end
  end

endmodule

// File: rtl/feature_window_linebuffer.sv
// Sliding-window line buffer: shifts accepted samples into a WIN-deep window
// that doubles as the xarray output, and flags complete, aligned windows.
module feature_window_linebuffer
  import lr_pkg::*;
#(
  parameter int unsigned DW      = FEAT_DW,
  parameter int unsigned WIN     = FEAT_WIN,
  parameter int unsigned ROW_LEN = 256,
  parameter int unsigned STRIDE  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_valid,
  input  logic                       in_sof,
  output logic                       in_ready,
  output logic [DW-1:0]              xarray [0:WIN-1],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(ROW_LEN)-1:0] win_col,
  output logic                       win_last
);

  localparam int unsigned PW = $clog2(ROW_LEN);

  if (ROW_LEN < WIN || STRIDE < 1) begin : g_bad_params
    $error("feature_window_linebuffer: need ROW_LEN >= WIN and STRIDE >= 1");
  end

  logic          accept;
  logic          emit;
  logic [PW-1:0] pos;
  logic          last;

  // Handshake: the window register is the shift register, so hold while a
  // window is pending and not being consumed.
  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
  end

  feature_window_ctrl #(
    .WIN     (WIN),
    .ROW_LEN (ROW_LEN),
    .STRIDE  (STRIDE)
  ) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept),
    .sof    (in_sof),
    .emit   (emit),
    .pos    (pos),
    .last   (last)
  );

  // Shift register: oldest sample at index 0, newest at WIN-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIN; i++) xarray[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i + 1 < WIN; i++) xarray[i] <= xarray[i+1];
      xarray[WIN-1] <= in_data;
    end
  end

  // Window-valid flag and its position tags, one cycle after the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      win_col   <= '0;
      win_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= emit;
      if (emit) begin
        win_col  <= pos;
        win_last <= last;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
